pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous reset, active-low (rst==0 at a rising clk edge resets).
REQ-003 SHALL have: D_icode_i  in  4  icode in decode stage.
REQ-004 SHALL have: d_srcA_i, d_srcB_i  in  4 each  decode source registers (F = RNONE).
REQ-005 SHALL have: E_icode_i  in  4;  E_dstM_i  in  4;  e_Cnd_i  in  1  execute-stage icode, load destination, branch condition.
REQ-006 SHALL have: M_icode_i  in  4;  m_stat_i  in  3;  W_stat_i  in  3  memory icode, memory-stage and writeback status.
REQ-007 SHALL have: F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o  out  1 each  pipeline register controls, active-high (ENABLE=1).
REQ-008 SHALL have: halted_o  out  1;  halt_stat_o  out  3  halt flag and latched cause.
REQ-009 SHALL have: lu_cnt_o, mp_cnt_o, ret_cnt_o, cyc_cnt_o  out  16 each  event counters.
REQ-010 Codes: IHALT 0, INOP 1, IMRMOVL 5, IJXX 7, IRET 9, IPOPL B, RNONE F; stat SBUB 0, SAOK 1, SHLT 2, SADR 3, SINS 4.

Function
REQ-011 lu (load/use) SHALL = E_icode_i in {IMRMOVL,IPOPL} and E_dstM_i!=RNONE and E_dstM_i in {d_srcA_i,d_srcB_i}.
REQ-012 rt SHALL = IRET present in any of D_icode_i, E_icode_i, M_icode_i.
REQ-013 mp (mispredict) SHALL = E_icode_i==IJXX and e_Cnd_i==0.
REQ-014 exc SHALL = m_stat_i in {SHLT,SADR,SINS} or W_stat_i in {SHLT,SADR,SINS}.
REQ-015 State RUN, outputs combinational, zero latency: F_stall=lu|rt; D_stall=lu; D_bubble=mp|(rt&!lu); E_bubble=mp|lu; M_bubble=exc; W_stall=W_stat_i in {SHLT,SADR,SINS}.
REQ-016 lu and mp simultaneous: E_bubble=1, D_bubble=1, D_stall=1; D_stall SHALL take priority over D_bubble at the register (D holds).
REQ-017 FSM states RUN, HALTED only; RUN->HALTED at edge where W_stat_i in {SHLT,SADR,SINS}; HALTED exits only by reset.
REQ-018 On RUN->HALTED, halt_stat_o SHALL latch W_stat_i; halted_o=1 from next cycle.
REQ-019 In HALTED: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0, regardless of inputs.
REQ-020 Counters in RUN only, saturating at FFFF (no wrap): lu_cnt +1 per cycle lu=1; mp_cnt +1 per cycle mp=1; ret_cnt +1 per cycle rt=1 and lu=0; cyc_cnt +1 every RUN cycle.
REQ-021 In HALTED all counters SHALL hold.
REQ-022 Counter updates and state transition in same cycle SHALL both take effect (the transition cycle is counted).

Reset
REQ-023 rst==0 at edge: state RUN, halted_o=0, halt_stat_o=SAOK, all counters 0.
REQ-024 While rst==0: F_stall=D_stall=W_stall=0, D_bubble=E_bubble=M_bubble=1 (flush), independent of other inputs.
REQ-025 Reset mid-HALTED or mid-hazard SHALL take full effect at that edge; first cycle after release behaves as RUN with zero counters.

Verification
REQ-026 E_icode=IMRMOVL, E_dstM=3, d_srcA=3, others clear -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; lu_cnt 0->1 next edge.
REQ-027 E_icode=IJXX, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; mp_cnt +1; same with e_Cnd=1 -> all controls 0.
REQ-028 IRET walked D->E->M over 3 cycles -> F_stall=1, D_bubble=1 each cycle, ret_cnt=3; combined with lu in cycle 1 -> D_stall=1, D_bubble=0, ret_cnt=2.
REQ-029 m_stat=SADR one cycle then W_stat=SADR -> M_bubble=1 first cycle; then W_stall=1, halted_o=1, halt_stat_o=3 next; later inputs ignored, counters frozen, until rst=0 restores reset values.
REQ-030 Force lu for 70000 cycles -> lu_cnt saturates at FFFF and stays; cyc_cnt saturates likewise.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller for a five-stage Y86-style pipeline.
// It decodes load/use, return, mispredict and exception hazards into
// stall/bubble controls. It also keeps a RUN/HALTED state with the latched halt
// cause, and saturating event counters that freeze once the pipeline halts.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  D_icode_i,
    input  logic [3:0]  d_srcA_i,
    input  logic [3:0]  d_srcB_i,
    input  logic [3:0]  E_icode_i,
    input  logic [3:0]  E_dstM_i,
    input  logic        e_Cnd_i,
    input  logic [3:0]  M_icode_i,
    input  logic [2:0]  m_stat_i,
    input  logic [2:0]  W_stat_i,
    output logic        F_stall_o,
    output logic        D_stall_o,
    output logic        D_bubble_o,
    output logic        E_bubble_o,
    output logic        M_bubble_o,
    output logic        W_stall_o,
    output logic        halted_o,
    output logic [2:0]  halt_stat_o,
    output logic [15:0] lu_cnt_o,
    output logic [15:0] mp_cnt_o,
    output logic [15:0] ret_cnt_o,
    output logic [15:0] cyc_cnt_o
);

    localparam logic [3:0] IMRMOVL = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPL   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [0:0] S_RUN    = 1'b0;
    localparam logic [0:0] S_HALTED = 1'b1;

    logic [0:0] state;
    logic       lu;
    logic       rt;
    logic       mp;
    logic       m_exc;
    logic       w_exc;
    logic       exc;

    // Increment by one when enabled, sticking at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF)) begin
            return v + 16'd1;
        end
        return v;
    endfunction

    // Hazard detection from the current stage contents.
    always_comb begin
        lu    = ((E_icode_i == IMRMOVL) || (E_icode_i == IPOPL)) &&
                (E_dstM_i != RNONE) &&
                ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
        rt    = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
        mp    = (E_icode_i == IJXX) && !e_Cnd_i;
        m_exc = (m_stat_i == SHLT) || (m_stat_i == SADR) || (m_stat_i == SINS);
        w_exc = (W_stat_i == SHLT) || (W_stat_i == SADR) || (W_stat_i == SINS);
        exc   = m_exc || w_exc;
    end

    // Pipeline register controls: a held reset flushes, a halted pipe freezes
    // everything, otherwise the hazards decide. When load/use and a bubble
    // request coincide, D_stall wins at the decode register so D holds.
    always_comb begin
        F_stall_o  = 1'b0;
        D_stall_o  = 1'b0;
        D_bubble_o = 1'b0;
        E_bubble_o = 1'b0;
        M_bubble_o = 1'b0;
        W_stall_o  = 1'b0;
        if (!rst) begin
            D_bubble_o = 1'b1;
            E_bubble_o = 1'b1;
            M_bubble_o = 1'b1;
        end else if (state == S_HALTED) begin
            F_stall_o  = 1'b1;
            D_stall_o  = 1'b1;
            W_stall_o  = 1'b1;
            E_bubble_o = 1'b1;
            M_bubble_o = 1'b1;
        end else begin
            F_stall_o  = lu || rt;
            D_stall_o  = lu;
            D_bubble_o = mp || (rt && !lu);
            E_bubble_o = mp || lu;
            M_bubble_o = exc;
            W_stall_o  = w_exc;
        end
    end

    // State, halt cause and counters; the cycle that enters HALTED is still counted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_RUN;
            halt_stat_o <= SAOK;
            lu_cnt_o    <= 16'd0;
            mp_cnt_o    <= 16'd0;
            ret_cnt_o   <= 16'd0;
            cyc_cnt_o   <= 16'd0;
        end else if (state == S_RUN) begin
            lu_cnt_o  <= sat_inc(lu_cnt_o, lu);
            mp_cnt_o  <= sat_inc(mp_cnt_o, mp);
            ret_cnt_o <= sat_inc(ret_cnt_o, rt && !lu);
            cyc_cnt_o <= sat_inc(cyc_cnt_o, 1'b1);
            if (w_exc) begin
                state       <= S_HALTED;
                halt_stat_o <= W_stat_i;
            end
        end
    end

    assign halted_o = (state == S_HALTED);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard testbench for pipe_ctrl. The stimulus process computes expected
// outputs from a behavioural model and queues them. A monitor pops the queue on
// each falling edge and compares the queued values with the DUT outputs.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic        e_Cnd;
    logic [2:0]  m_stat, W_stat;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
    logic [2:0]  halt_stat;
    logic [15:0] lu_cnt, mp_cnt, ret_cnt, cyc_cnt;

    typedef struct {
        logic [73:0] exp;
        bit          chk;
        string       tag;
    } entry_t;

    entry_t sb[$];
    int checks = 0;
    int passed = 0;

    bit mHalted;
    int mHstat, mLu, mMp, mRet, mCyc;
    int haltAge;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
        .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_Cnd_i(e_Cnd),
        .M_icode_i(M_icode), .m_stat_i(m_stat), .W_stat_i(W_stat),
        .F_stall_o(F_stall), .D_stall_o(D_stall), .D_bubble_o(D_bubble),
        .E_bubble_o(E_bubble), .M_bubble_o(M_bubble), .W_stall_o(W_stall),
        .halted_o(halted), .halt_stat_o(halt_stat),
        .lu_cnt_o(lu_cnt), .mp_cnt_o(mp_cnt), .ret_cnt_o(ret_cnt), .cyc_cnt_o(cyc_cnt)
    );

    function automatic bit isExc(input int s);
        return (s == 2) || (s == 3) || (s == 4);
    endfunction

    function automatic int satInc(input int v, input bit en);
        return (en && v < 65535) ? v + 1 : v;
    endfunction

    // Drive one cycle of inputs, queue the model's expectation, advance the model.
    task automatic applyStimulus(input bit r, input int di, input int sa, input int sbr,
                                 input int ei, input int ed, input bit cnd, input int mi,
                                 input int ms, input int ws, input string tag, input bit chk);
        bit lu, rt, mp;
        logic [5:0] ctl;
        entry_t e;
        @(posedge clk);
        #1;
        rst = r; D_icode = 4'(di); d_srcA = 4'(sa); d_srcB = 4'(sbr);
        E_icode = 4'(ei); E_dstM = 4'(ed); e_Cnd = cnd; M_icode = 4'(mi);
        m_stat = 3'(ms); W_stat = 3'(ws);
        lu = (ei == 5 || ei == 11) && ed != 15 && (ed == sa || ed == sbr);
        rt = (di == 9) || (ei == 9) || (mi == 9);
        mp = (ei == 7) && !cnd;
        if (!r)
            ctl = 6'b001110;
        else if (mHalted)
            ctl = 6'b110111;
        else
            ctl = {lu | rt, lu, mp | (rt & !lu), mp | lu, isExc(ms) | isExc(ws), isExc(ws)};
        e.exp = {ctl, mHalted, 3'(mHstat), 16'(mLu), 16'(mMp), 16'(mRet), 16'(mCyc)};
        e.chk = chk;
        e.tag = tag;
        sb.push_back(e);
        if (!r) begin
            mHalted = 0; mHstat = 1; mLu = 0; mMp = 0; mRet = 0; mCyc = 0;
        end else if (!mHalted) begin
            mLu  = satInc(mLu, lu);
            mMp  = satInc(mMp, mp);
            mRet = satInc(mRet, rt && !lu);
            mCyc = satInc(mCyc, 1'b1);
            if (isExc(ws)) begin
                mHalted = 1;
                mHstat  = ws;
            end
        end
    endtask

    task automatic idle(input string tag);
        applyStimulus(1, 1, 15, 15, 1, 15, 0, 1, 1, 1, tag, 1);
    endtask

    task automatic checkOutput(input entry_t e);
        logic [73:0] act;
        act = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted, halt_stat,
               lu_cnt, mp_cnt, ret_cnt, cyc_cnt};
        checks++;
        if (act === e.exp)
            passed++;
        else
            $display("[TB] FAIL %s: got %h expected %h", e.tag, act, e.exp);
    endtask

    // Monitor: one queued expectation per cycle, compared mid-cycle.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) checkOutput(e);
            end
        end
    end

    function automatic int randIcode();
        case ($urandom_range(0, 7))
            0: return 0;
            1: return 1;
            2: return 5;
            3: return 7;
            4: return 9;
            5: return 11;
            default: return int'($urandom_range(0, 15));
        endcase
    endfunction

    function automatic int randReg();
        int v;
        v = int'($urandom_range(0, 4));
        return (v == 4) ? 15 : v;
    endfunction

    function automatic int randStat(input int rare);
        int v;
        v = int'($urandom_range(0, rare));
        if (v == 0) return 0;
        if (v == 1) return 2;
        if (v == 2) return 3;
        if (v == 3) return 4;
        return 1;
    endfunction

    // Stimulus: directed scenarios, a randomized run, then counter saturation.
    initial begin
        rst = 0; D_icode = 1; d_srcA = 15; d_srcB = 15; E_icode = 1; E_dstM = 15;
        e_Cnd = 0; M_icode = 1; m_stat = 1; W_stat = 1;
        mHalted = 0; mHstat = 1; mLu = 0; mMp = 0; mRet = 0; mCyc = 0;
        repeat (2) @(posedge clk);

        applyStimulus(0, 9, 3, 3, 5, 3, 0, 9, 3, 3, "reset_flush", 1);
        idle("run_idle");
        applyStimulus(1, 1, 3, 15, 5, 3, 0, 1, 1, 1, "load_use", 1);
        idle("lu_count");
        applyStimulus(1, 1, 15, 15, 7, 15, 0, 1, 1, 1, "mispredict", 1);
        applyStimulus(1, 1, 15, 15, 7, 15, 1, 1, 1, 1, "branch_taken", 1);
        applyStimulus(1, 9, 15, 15, 1, 15, 0, 1, 1, 1, "ret_D", 1);
        applyStimulus(1, 1, 15, 15, 9, 15, 0, 1, 1, 1, "ret_E", 1);
        applyStimulus(1, 1, 15, 15, 1, 15, 0, 9, 1, 1, "ret_M", 1);
        idle("ret_count");
        applyStimulus(1, 9, 3, 15, 11, 3, 0, 1, 1, 1, "ret_with_lu", 1);
        applyStimulus(1, 1, 15, 15, 9, 15, 0, 1, 1, 1, "ret_E2", 1);
        applyStimulus(1, 1, 15, 15, 1, 15, 0, 9, 1, 1, "ret_M2", 1);
        idle("ret_count2");
        applyStimulus(1, 1, 15, 15, 1, 15, 0, 1, 3, 1, "m_exc", 1);
        applyStimulus(1, 1, 15, 15, 1, 15, 0, 1, 1, 3, "w_exc", 1);
        for (int i = 0; i < 4; i++)
            applyStimulus(1, randIcode(), randReg(), randReg(), randIcode(), randReg(),
                          1'($urandom_range(0, 1)), randIcode(), randStat(9), randStat(9),
                          "halted_hold", 1);
        applyStimulus(0, 1, 15, 15, 1, 15, 0, 1, 1, 1, "reset_halted", 1);
        idle("after_reset");

        haltAge = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = !(($urandom_range(0, 99) == 0) || (mHalted && haltAge > 4));
            haltAge = (mHalted && r) ? haltAge + 1 : 0;
            applyStimulus(r, randIcode(), randReg(), randReg(), randIcode(), randReg(),
                          1'($urandom_range(0, 1)), randIcode(), randStat(39), randStat(199),
                          "random", 1);
        end

        applyStimulus(0, 1, 15, 15, 1, 15, 0, 1, 1, 1, "sat_reset", 1);
        for (int i = 0; i < 66000; i++)
            applyStimulus(1, 1, 2, 15, 5, 2, 0, 1, 1, 1, "saturate",
                          (i % 4096 == 0) || (i >= 65530 && i <= 65540) || (i >= 65995));

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb.size() == 0)
            passed++;
        else
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
